// File: rtl/bias_feeder_if.sv
// bias_feeder_if: bias load port and accumulator stream port of the bias feeder
interface bias_feeder_if #(
    parameter int DATA_W = 16,
    parameter int COL_W  = 3
);
    logic                     clear_i;
    logic                     load_valid_i;
    logic signed [DATA_W-1:0] load_data_i;
    logic                     load_ready_o;
    logic                     valid_i;
    logic signed [DATA_W-1:0] data_i;
    logic                     valid_o;
    logic signed [DATA_W-1:0] data_o;
    logic signed [DATA_W-1:0] bias_o;
    logic [COL_W-1:0]         col_o;
    logic                     stream_ready_o;
    logic                     err_o;

    modport master (
        output clear_i, load_valid_i, load_data_i, valid_i, data_i,
        input  load_ready_o, valid_o, data_o, bias_o, col_o, stream_ready_o, err_o
    );

    modport slave (
        input  clear_i, load_valid_i, load_data_i, valid_i, data_i,
        output load_ready_o, valid_o, data_o, bias_o, col_o, stream_ready_o, err_o
    );
endinterface

// File: rtl/bias_feeder.sv
// bias_feeder: stores per-column biases and re-times the accumulator stream with its column's bias
module bias_feeder #(
    parameter int NUM_COLS = 8,
    parameter int DATA_W   = 16,
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input logic          clk_i,
    input logic          rst_i,
    bias_feeder_if.slave bus
);
    typedef enum logic {LOAD, STREAM} state_t;

    localparam logic [COL_W-1:0] LAST = COL_W'(NUM_COLS - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] bias [NUM_COLS];
    logic [COL_W-1:0]         load_ptr;
    logic [COL_W-1:0]         col;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= LOAD;
            load_ptr           <= '0;
            col                <= '0;
            for (int i = 0; i < NUM_COLS; i++) bias[i] <= '0;
            bus.valid_o        <= 1'b0;
            bus.data_o         <= '0;
            bus.bias_o         <= '0;
            bus.col_o          <= '0;
            bus.err_o          <= 1'b0;
            bus.load_ready_o   <= 1'b1;
            bus.stream_ready_o <= 1'b0;
        end else if (bus.clear_i) begin
            // clear keeps the last data/bias/col visible but drops everything else
            state              <= LOAD;
            load_ptr           <= '0;
            col                <= '0;
            for (int i = 0; i < NUM_COLS; i++) bias[i] <= '0;
            bus.valid_o        <= 1'b0;
            bus.err_o          <= 1'b0;
            bus.load_ready_o   <= 1'b1;
            bus.stream_ready_o <= 1'b0;
        end else begin
            bus.valid_o <= 1'b0;
            if (state == LOAD) begin
                if (bus.valid_i) bus.err_o <= 1'b1;
                if (bus.load_valid_i) begin
                    bias[load_ptr] <= bus.load_data_i;
                    load_ptr       <= (load_ptr == LAST) ? '0 : load_ptr + 1'b1;
                    if (load_ptr == LAST) begin
                        state              <= STREAM;
                        bus.load_ready_o   <= 1'b0;
                        bus.stream_ready_o <= 1'b1;
                    end
                end
            end else if (bus.valid_i) begin
                bus.valid_o <= 1'b1;
                bus.data_o  <= bus.data_i;
                bus.bias_o  <= bias[col];
                bus.col_o   <= col;
                col         <= (col == LAST) ? '0 : col + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bias_feeder.sv
// tb_bias_feeder: directed checks of bias loading, streaming, error, clear and reset behaviour
module tb_bias_feeder;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    bias_feeder_if #(.DATA_W(16), .COL_W(2)) bus ();

    bias_feeder #(.NUM_COLS(4), .DATA_W(16)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        bus.clear_i      = 1'b0;
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = '0;
        bus.valid_i      = 1'b0;
        bus.data_i       = '0;
    endtask

    task automatic do_reset;
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic load4(input logic signed [15:0] a, b, c, d);
        logic signed [15:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = v[i];
            step();
        end
        bus.load_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        total++; if (bus.data_o !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus.data_o); end
        total++; if (bus.bias_o !== 16'h0) begin bad++; $display("FAIL reset_bias got=%h exp=0000", bus.bias_o); end
        total++; if (bus.col_o !== 2'd0) begin bad++; $display("FAIL reset_col got=%0d exp=0", bus.col_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
        total++; if (bus.load_ready_o !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready_o); end
        total++; if (bus.stream_ready_o !== 1'b0) begin bad++; $display("FAIL reset_stream_ready got=%b exp=0", bus.stream_ready_o); end
    endtask

    task automatic test_back_to_back;
        logic signed [15:0] eb [4];
        eb = '{16'sd10, -16'sd20, 16'sd30, -16'sd40};
        do_reset();
        load4(10, -20, 30, -40);
        total++; if (bus.load_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_load_ready got=%b exp=0", bus.load_ready_o); end
        total++; if (bus.stream_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_stream_ready got=%b exp=1", bus.stream_ready_o); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_pre_valid got=%b exp=0", bus.valid_o); end
        for (int i = 0; i < 8; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = 16'(i + 1);
            step();
            total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.valid_o); end
            total++; if (bus.data_o !== 16'(i + 1)) begin bad++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, bus.data_o, i + 1); end
            total++; if (bus.bias_o !== eb[i % 4]) begin bad++; $display("FAIL b2b_bias[%0d] got=%0d exp=%0d", i, bus.bias_o, eb[i % 4]); end
            total++; if (bus.col_o !== 2'(i % 4)) begin bad++; $display("FAIL b2b_col[%0d] got=%0d exp=%0d", i, bus.col_o, i % 4); end
        end
        bus.valid_i = 1'b0;
        step();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_post_valid got=%b exp=0", bus.valid_o); end
    endtask

    task automatic test_gaps;
        logic               v  [5];
        logic signed [15:0] ed [5];
        logic signed [15:0] eb [5];
        logic [1:0]         ec [5];
        v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ed = '{16'sd100, 16'sd100, 16'sd100, 16'sd103, 16'sd104};
        eb = '{16'sd11, 16'sd11, 16'sd11, 16'sd22, 16'sd33};
        ec = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        do_reset();
        load4(11, 22, 33, 44);
        for (int i = 0; i < 5; i++) begin
            bus.valid_i      = v[i];
            bus.data_i       = 16'(100 + i);
            bus.load_valid_i = ~v[i];
            bus.load_data_i  = 16'sd99;
            step();
            total++; if (bus.valid_o !== v[i]) begin bad++; $display("FAIL gap_valid[%0d] got=%b exp=%b", i, bus.valid_o, v[i]); end
            total++; if (bus.data_o !== ed[i]) begin bad++; $display("FAIL gap_data[%0d] got=%0d exp=%0d", i, bus.data_o, ed[i]); end
            total++; if (bus.bias_o !== eb[i]) begin bad++; $display("FAIL gap_bias[%0d] got=%0d exp=%0d", i, bus.bias_o, eb[i]); end
            total++; if (bus.col_o !== ec[i]) begin bad++; $display("FAIL gap_col[%0d] got=%0d exp=%0d", i, bus.col_o, ec[i]); end
        end
        bus.load_valid_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 16'sd200;
        step();
        total++; if (bus.bias_o !== 16'sd44) begin bad++; $display("FAIL gap_bias_col3 got=%0d exp=44", bus.bias_o); end
        total++; if (bus.col_o !== 2'd3) begin bad++; $display("FAIL gap_col3 got=%0d exp=3", bus.col_o); end
        step();
        total++; if (bus.bias_o !== 16'sd11) begin bad++; $display("FAIL gap_bias_col0 got=%0d exp=11", bus.bias_o); end
        total++; if (bus.col_o !== 2'd0) begin bad++; $display("FAIL gap_col0 got=%0d exp=0", bus.col_o); end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_err_in_load;
        do_reset();
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 16'sd1;
        step();
        bus.load_data_i  = 16'sd2;
        step();
        bus.load_valid_i = 1'b0;
        bus.valid_i      = 1'b1;
        bus.data_i       = 16'sd7;
        step();
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL err_valid got=%b exp=0", bus.valid_o); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.err_o); end
        bus.valid_i = 1'b0;
        step();
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.err_o); end
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 16'sd3;
        step();
        bus.load_data_i  = 16'sd4;
        step();
        bus.load_valid_i = 1'b0;
        bus.valid_i      = 1'b1;
        bus.data_i       = 16'sd9;
        step();
        bus.valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL err_stream_valid got=%b exp=1", bus.valid_o); end
        total++; if (bus.bias_o !== 16'sd1) begin bad++; $display("FAIL err_stream_bias got=%0d exp=1", bus.bias_o); end
        total++; if (bus.col_o !== 2'd0) begin bad++; $display("FAIL err_stream_col got=%0d exp=0", bus.col_o); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL err_stream_err got=%b exp=1", bus.err_o); end
    endtask

    task automatic test_clear;
        do_reset();
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        load4(1, 2, 3, 4);
        bus.valid_i = 1'b1;
        step();
        step();
        bus.clear_i = 1'b1;
        bus.data_i  = 16'sd55;
        step();
        bus.clear_i = 1'b0;
        bus.valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", bus.valid_o); end
        total++; if (bus.load_ready_o !== 1'b1) begin bad++; $display("FAIL clr_load_ready got=%b exp=1", bus.load_ready_o); end
        total++; if (bus.stream_ready_o !== 1'b0) begin bad++; $display("FAIL clr_stream_ready got=%b exp=0", bus.stream_ready_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", bus.err_o); end
        load4(5, 6, 7, 8);
        bus.valid_i = 1'b1;
        bus.data_i  = 16'sd60;
        step();
        total++; if (bus.bias_o !== 16'sd5) begin bad++; $display("FAIL clr_bias0 got=%0d exp=5", bus.bias_o); end
        total++; if (bus.col_o !== 2'd0) begin bad++; $display("FAIL clr_col0 got=%0d exp=0", bus.col_o); end
        step();
        bus.valid_i = 1'b0;
        total++; if (bus.bias_o !== 16'sd6) begin bad++; $display("FAIL clr_bias1 got=%0d exp=6", bus.bias_o); end
        total++; if (bus.col_o !== 2'd1) begin bad++; $display("FAIL clr_col1 got=%0d exp=1", bus.col_o); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        load4(-5, 6, -7, 8);
        bus.valid_i = 1'b1;
        bus.data_i  = 16'sd77;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rstm_valid got=%b exp=0", bus.valid_o); end
        total++; if (bus.data_o !== 16'h0) begin bad++; $display("FAIL rstm_data got=%h exp=0000", bus.data_o); end
        total++; if (bus.bias_o !== 16'h0) begin bad++; $display("FAIL rstm_bias got=%h exp=0000", bus.bias_o); end
        total++; if (bus.col_o !== 2'd0) begin bad++; $display("FAIL rstm_col got=%0d exp=0", bus.col_o); end
        total++; if (bus.load_ready_o !== 1'b1) begin bad++; $display("FAIL rstm_load_ready got=%b exp=1", bus.load_ready_o); end
        total++; if (bus.stream_ready_o !== 1'b0) begin bad++; $display("FAIL rstm_stream_ready got=%b exp=0", bus.stream_ready_o); end
        step();
        bus.valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rstm_drop got=%b exp=0", bus.valid_o); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL rstm_err got=%b exp=1", bus.err_o); end
    endtask

    task automatic test_signed;
        logic [15:0] eb [4];
        eb = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        do_reset();
        load4(32767, -32768, 0, 0);
        do_reset();
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 16'sd32767;
        step();
        bus.load_data_i  = -16'sd32768;
        step();
        bus.load_data_i  = 16'sd0;
        step();
        bus.load_data_i  = -16'sd1;
        bus.valid_i      = 1'b1;
        bus.data_i       = -16'sd32768;
        step();
        bus.load_valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL sgn_last_load_valid got=%b exp=0", bus.valid_o); end
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL sgn_last_load_err got=%b exp=1", bus.err_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL sgn_valid[%0d] got=%b exp=1", i, bus.valid_o); end
            total++; if (bus.data_o !== 16'h8000) begin bad++; $display("FAIL sgn_data[%0d] got=%h exp=8000", i, bus.data_o); end
            total++; if (bus.bias_o !== eb[i]) begin bad++; $display("FAIL sgn_bias[%0d] got=%h exp=%h", i, bus.bias_o, eb[i]); end
        end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_err_in_load();
        test_clear();
        test_reset_mid();
        test_signed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
